// File: rtl/uart_rx_param.sv
// Oversampled UART receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// framing-error reporting; optional parity checking is enabled by UART_RX_PARITY_EN.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int DATA_BITS  = 7,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 parity_err_out,
  output logic [2:0]           state_out
);

  localparam int CW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS);
  localparam int MID = OVERSAMPLE / 2;
  localparam logic [CW-1:0] C_MIDM1   = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID     = CW'(MID);
  localparam logic [CW-1:0] C_MIDP1   = CW'(MID + 1);
  localparam logic [CW-1:0] C_LAST    = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] C_LASTBIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic                 r_s1, r_rxS;
  state_t               r_state, w_stateNext;
  logic [CW-1:0]        r_sampleCnt, w_cntNext;
  logic [BW-1:0]        r_bitCnt, w_bitNext;
  logic [DATA_BITS-1:0] r_shift, w_shiftNext;
  logic [DATA_BITS-1:0] r_data, w_dataNext;
  logic [1:0]           r_smp, w_smpNext;
  logic                 r_valid, w_validNext;
  logic                 r_ferr, w_ferrNext;
  logic                 w_vote;
`ifdef UART_RX_PARITY_EN
  localparam logic C_ODD = (PARITY_ODD != 0);
  logic                 r_perr, w_perrNext;
  logic                 r_parMis, w_parMisNext;
`endif

  // Vote combines the two stored mid-bit samples with the live third sample
  assign w_vote = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rxS) | (r_smp[1] & r_rxS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1        <= 1'b1;
      r_rxS       <= 1'b1;
      r_state     <= S_IDLE;
      r_sampleCnt <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_smp       <= '0;
      r_valid     <= 1'b0;
      r_ferr      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr      <= 1'b0;
      r_parMis    <= 1'b0;
`endif
    end else begin
      r_s1        <= rx;
      r_rxS       <= r_s1;
      r_state     <= w_stateNext;
      r_sampleCnt <= w_cntNext;
      r_bitCnt    <= w_bitNext;
      r_shift     <= w_shiftNext;
      r_data      <= w_dataNext;
      r_smp       <= w_smpNext;
      r_valid     <= w_validNext;
      r_ferr      <= w_ferrNext;
`ifdef UART_RX_PARITY_EN
      r_perr      <= w_perrNext;
      r_parMis    <= w_parMisNext;
`endif
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_cntNext    = r_sampleCnt;
    w_bitNext    = r_bitCnt;
    w_shiftNext  = r_shift;
    w_dataNext   = r_data;
    w_smpNext    = r_smp;
    w_validNext  = 1'b0;
    w_ferrNext   = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_perrNext   = 1'b0;
    w_parMisNext = r_parMis;
`endif
    if (ena) begin
      if (r_sampleCnt == C_MIDM1) w_smpNext[0] = r_rxS;
      if (r_sampleCnt == C_MID)   w_smpNext[1] = r_rxS;
      case (r_state)
        S_IDLE: begin
          if (!r_rxS) begin
            w_stateNext = S_START;
            w_cntNext   = '0;
          end
        end
        S_START: begin
          w_cntNext = r_sampleCnt + 1'b1;
          if (r_sampleCnt == C_MIDP1 && w_vote) begin
            w_stateNext = S_IDLE;
            w_cntNext   = '0;
          end else if (r_sampleCnt == C_LAST) begin
            w_stateNext = S_DATA;
            w_cntNext   = '0;
            w_bitNext   = '0;
          end
        end
        S_DATA: begin
          w_cntNext = r_sampleCnt + 1'b1;
          if (r_sampleCnt == C_MIDP1)
            w_shiftNext = {w_vote, r_shift[DATA_BITS-1:1]};
          if (r_sampleCnt == C_LAST) begin
            w_cntNext = '0;
            if (r_bitCnt == C_LASTBIT) begin
`ifdef UART_RX_PARITY_EN
              w_stateNext = S_PARITY;
`else
              w_stateNext = S_STOP;
`endif
            end else begin
              w_bitNext = r_bitCnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          w_cntNext = r_sampleCnt + 1'b1;
          if (r_sampleCnt == C_MIDP1)
            w_parMisNext = w_vote ^ (^r_shift) ^ C_ODD;
          if (r_sampleCnt == C_LAST) begin
            w_stateNext = S_STOP;
            w_cntNext   = '0;
          end
        end
`endif
        // Leave STOP at the vote so a back-to-back start edge is not missed
        S_STOP: begin
          w_cntNext = r_sampleCnt + 1'b1;
          if (r_sampleCnt == C_MIDP1) begin
            w_stateNext = S_IDLE;
            w_cntNext   = '0;
            if (!w_vote)
              w_ferrNext = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (r_parMis)
              w_perrNext = 1'b1;
`endif
            else begin
              w_dataNext  = r_shift;
              w_validNext = 1'b1;
            end
          end
        end
        default: begin
          w_stateNext = S_IDLE;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  assign data_out      = r_data;
  assign valid_out     = r_valid;
  assign frame_err_out = r_ferr;
  assign state_out     = r_state;
`ifdef UART_RX_PARITY_EN
  assign parity_err_out = r_perr;
`else
  assign parity_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: nominal frame and latency, glitch rejection,
// framing error, majority vote, gated ena, reset mid-frame; parity cases with UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_param;

`ifdef UART_RX_PARITY_EN
  localparam int PAR_ON = 1;
`else
  localparam int PAR_ON = 0;
`endif
  localparam int LAT = 72 + 8 * PAR_ON;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       rx = 1'b1;
  logic [6:0] data_out;
  logic       valid_out, frame_err_out, parity_err_out;
  logic [2:0] state_out;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int startEdge = 0;
  int validCnt = 0, ferrCnt = 0, perrCnt = 0, lastValid = 0;
  bit halfRate = 1'b0;

  uart_rx_param dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx),
    .data_out(data_out), .valid_out(valid_out), .frame_err_out(frame_err_out),
    .parity_err_out(parity_err_out), .state_out(state_out)
  );

`ifdef UART_RX_PARITY_EN
  logic       rxP = 1'b1;
  logic [7:0] dataP;
  logic       validP, ferrP, perrP;
  logic [2:0] stateP;
  int validPCnt = 0, perrPCnt = 0;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_ODD(0)) dutP (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rxP),
    .data_out(dataP), .valid_out(validP), .frame_err_out(ferrP),
    .parity_err_out(perrP), .state_out(stateP)
  );

  always @(posedge clk) begin
    #1;
    if (validP) validPCnt++;
    if (perrP) perrPCnt++;
  end
`endif

  always #5 clk = ~clk;

  // Count pulse cycles of the main instance and remember the edge of the last valid
  always @(posedge clk) begin
    cycle++;
    #1;
    if (valid_out) begin
      validCnt++;
      lastValid = cycle;
    end
    if (frame_err_out) ferrCnt++;
    if (parity_err_out) perrCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitClk();
    @(negedge clk);
    if (halfRate) ena = ~ena;
  endtask

  task automatic setLine(input logic v, input bit toP);
`ifdef UART_RX_PARITY_EN
    if (toP) rxP = v;
    else rx = v;
`else
    if (!toP) rx = v;
`endif
  endtask

  task automatic clearCounts();
    validCnt = 0;
    ferrCnt  = 0;
    perrCnt  = 0;
`ifdef UART_RX_PARITY_EN
    validPCnt = 0;
    perrPCnt  = 0;
`endif
  endtask

  // Sends start, nbits LSB first, optional parity (computed even ^ flip), stop; spike at offset 4 of bit spikeBit
  task automatic applyStimulus(input logic [8:0] data, input int nbits, input bit withPar,
                               input logic parFlip, input logic stopBit, input int spikeBit, input bit toP);
    int   per;
    logic par;
    per = halfRate ? 16 : 8;
    par = parFlip;
    startEdge = cycle + 1;
    setLine(1'b0, toP);
    repeat (per) waitClk();
    for (int i = 0; i < nbits; i++) begin
      par = par ^ data[i];
      setLine(data[i], toP);
      if (i == spikeBit) begin
        repeat (4) waitClk();
        setLine(~data[i], toP);
        waitClk();
        setLine(data[i], toP);
        repeat (per - 5) waitClk();
      end else begin
        repeat (per) waitClk();
      end
    end
    if (withPar) begin
      setLine(par, toP);
      repeat (per) waitClk();
    end
    setLine(stopBit, toP);
    repeat (per) waitClk();
    setLine(1'b1, toP);
  endtask

  initial begin
    repeat (3) waitClk();
    checkOutput("reset data_out", 32'(data_out), 32'h0);
    checkOutput("reset valid_out", 32'(valid_out), 32'h0);
    checkOutput("reset frame_err_out", 32'(frame_err_out), 32'h0);
    checkOutput("reset parity_err_out", 32'(parity_err_out), 32'h0);
    checkOutput("reset state_out", 32'(state_out), 32'h0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (4) waitClk();

    $display("[TB] nominal frame 0x55");
    clearCounts();
    applyStimulus(9'h055, 7, PAR_ON != 0, 1'b0, 1'b1, -1, 1'b0);
    repeat (16) waitClk();
    checkOutput("t1 valid count", 32'(validCnt), 32'd1);
    checkOutput("t1 latency", 32'(lastValid - startEdge), 32'(LAT));
    checkOutput("t1 data_out", 32'(data_out), 32'h55);
    checkOutput("t1 frame_err count", 32'(ferrCnt), 32'd0);
    checkOutput("t1 parity_err count", 32'(perrCnt), 32'd0);
    checkOutput("t1 state idle", 32'(state_out), 32'd0);

    $display("[TB] 2-clock glitch");
    clearCounts();
    rx = 1'b0;
    repeat (2) waitClk();
    rx = 1'b1;
    waitClk();
    checkOutput("t2 state start", 32'(state_out), 32'd1);
    repeat (8) waitClk();
    checkOutput("t2 state idle", 32'(state_out), 32'd0);
    checkOutput("t2 pulse count", 32'(validCnt + ferrCnt + perrCnt), 32'd0);
    checkOutput("t2 data_out", 32'(data_out), 32'h55);

    $display("[TB] framing error on 0x2A");
    clearCounts();
    applyStimulus(9'h02A, 7, PAR_ON != 0, 1'b0, 1'b0, -1, 1'b0);
    repeat (24) waitClk();
    checkOutput("t3 frame_err count", 32'(ferrCnt), 32'd1);
    checkOutput("t3 valid count", 32'(validCnt), 32'd0);
    checkOutput("t3 parity_err count", 32'(perrCnt), 32'd0);
    checkOutput("t3 data_out held", 32'(data_out), 32'h55);
    checkOutput("t3 state idle", 32'(state_out), 32'd0);

    $display("[TB] spikes on 0x0F");
    clearCounts();
    applyStimulus(9'h00F, 7, PAR_ON != 0, 1'b0, 1'b1, 0, 1'b0);
    repeat (16) waitClk();
    checkOutput("t4a valid count", 32'(validCnt), 32'd1);
    checkOutput("t4a data_out", 32'(data_out), 32'h0F);
    clearCounts();
    applyStimulus(9'h00F, 7, PAR_ON != 0, 1'b0, 1'b1, 4, 1'b0);
    repeat (16) waitClk();
    checkOutput("t4b valid count", 32'(validCnt), 32'd1);
    checkOutput("t4b data_out", 32'(data_out), 32'h0F);
    checkOutput("t4b frame_err count", 32'(ferrCnt), 32'd0);

    $display("[TB] half-rate ena, 0x33");
    clearCounts();
    halfRate = 1'b1;
    applyStimulus(9'h033, 7, PAR_ON != 0, 1'b0, 1'b1, -1, 1'b0);
    repeat (40) waitClk();
    halfRate = 1'b0;
    ena = 1'b1;
    checkOutput("t5 valid count", 32'(validCnt), 32'd1);
    checkOutput("t5 data_out", 32'(data_out), 32'h33);
    checkOutput("t5 error count", 32'(ferrCnt + perrCnt), 32'd0);
    checkOutput("t5 state idle", 32'(state_out), 32'd0);

    $display("[TB] reset mid-frame, then 0x11");
    rx = 1'b0;
    repeat (8) waitClk();
    rx = 1'b1;
    repeat (20) waitClk();
    checkOutput("t6 state data", 32'(state_out), 32'd2);
    rst_n = 1'b0;
    waitClk();
    checkOutput("t6 reset state", 32'(state_out), 32'd0);
    checkOutput("t6 reset data_out", 32'(data_out), 32'h0);
    checkOutput("t6 reset valid_out", 32'(valid_out), 32'h0);
    repeat (3) waitClk();
    clearCounts();
    rst_n = 1'b1;
    repeat (20) waitClk();
    checkOutput("t6 no pulses after reset", 32'(validCnt + ferrCnt + perrCnt), 32'd0);
    applyStimulus(9'h011, 7, PAR_ON != 0, 1'b0, 1'b1, -1, 1'b0);
    repeat (16) waitClk();
    checkOutput("t6 valid count", 32'(validCnt), 32'd1);
    checkOutput("t6 data_out", 32'(data_out), 32'h11);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity instance, 0xA5");
    clearCounts();
    applyStimulus(9'h0A5, 8, 1'b1, 1'b0, 1'b1, -1, 1'b1);
    repeat (16) waitClk();
    checkOutput("t7 valid count", 32'(validPCnt), 32'd1);
    checkOutput("t7 parity_err count", 32'(perrPCnt), 32'd0);
    checkOutput("t7 data_out", 32'(dataP), 32'hA5);
    clearCounts();
    applyStimulus(9'h0A5, 8, 1'b1, 1'b1, 1'b1, -1, 1'b1);
    repeat (16) waitClk();
    checkOutput("t8 valid count", 32'(validPCnt), 32'd0);
    checkOutput("t8 parity_err count", 32'(perrPCnt), 32'd1);
    checkOutput("t8 data_out held", 32'(dataP), 32'hA5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
